// File: rtl/exc_collector.sv
// exc_collector
//   Carries one exception record per pipeline stage (D/E/M), merges the
//   F/D/E/M detector flags and NUM_IRQ interrupt lines, and decides
//   exception entry at M. Owns EXL, EPC, BD and the pending-interrupt
//   latch; drives flush and redirect toward CP0 / PC-select.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   stall                      hold D record, insert bubble into E
//   valid_f exc_f code_f pc_f bd_f   F-stage record fields
//   exc_d/code_d, exc_e/code_e, exc_m/code_m   per-stage detector flags
//   eret_m                     eret in M
//   hw_int, im, ie             interrupt lines, mask, global enable
//   take, cause                event taken this cycle and its code (0 = Int)
//   epc, bd, exl, ip           registered CP0-side state
//   flush, redirect            pipeline flush and target PC
module exc_collector #(
  parameter int              NUM_IRQ = 6,
  parameter int              AW      = 32,
  parameter logic [AW-1:0]   HANDLER = 'h0000_4180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               valid_f,
  input  logic               exc_f,
  input  logic [4:0]         code_f,
  input  logic [AW-1:0]      pc_f,
  input  logic               bd_f,
  input  logic               exc_d,
  input  logic [4:0]         code_d,
  input  logic               exc_e,
  input  logic [4:0]         code_e,
  input  logic               exc_m,
  input  logic [4:0]         code_m,
  input  logic               eret_m,
  input  logic [NUM_IRQ-1:0] hw_int,
  input  logic [NUM_IRQ-1:0] im,
  input  logic               ie,
  output logic               take,
  output logic [4:0]         cause,
  output logic [AW-1:0]      epc,
  output logic               bd,
  output logic               exl,
  output logic [NUM_IRQ-1:0] ip,
  output logic               flush,
  output logic [AW-1:0]      redirect
);

  typedef struct packed {
    logic          vld;
    logic          exc;
    logic [4:0]    code;
    logic [AW-1:0] pc;
    logic          bd;
  } rec_t;

  // Earliest stage wins: a record that already carries an exception keeps
  // its code; flags arriving on an invalid record are ignored.
  function automatic rec_t merge_rec(input rec_t r, input logic flag,
                                     input logic [4:0] code);
    rec_t o;
    o = r;
    if (r.vld && !r.exc && flag) begin
      o.exc  = 1'b1;
      o.code = code;
    end
    return o;
  endfunction

  // Delay-slot instructions restart at the branch; wraps modulo 2^AW.
  function automatic logic [AW-1:0] epc_of(input rec_t r);
    return r.bd ? (r.pc - AW'(4)) : r.pc;
  endfunction

  rec_t rec_f;
  rec_t rec_p0, rec_p1, rec_p2;        // D, E, M records
  rec_t mrg_p0, mrg_p1, mrg_p2;        // records with their stage flag merged
  logic irq_req;

  // F stage: record assembled straight from the fetch-side inputs
  always_comb begin
    rec_f.vld  = valid_f;
    rec_f.exc  = valid_f & exc_f;
    rec_f.code = (valid_f & exc_f) ? code_f : 5'd0;
    rec_f.pc   = pc_f;
    rec_f.bd   = bd_f;
  end

  assign mrg_p0 = merge_rec(rec_p0, exc_d, code_d);
  assign mrg_p1 = merge_rec(rec_p1, exc_e, code_e);
  assign mrg_p2 = merge_rec(rec_p2, exc_m, code_m);

  // M stage: entry decision. Interrupts outrank synchronous exceptions, and
  // a bubble in M never takes, so a pending interrupt waits for a real
  // instruction to attach EPC to.
  assign irq_req = ie & ~exl & (|(ip & im));

  always_comb begin
    take  = mrg_p2.vld & ~exl & (irq_req | mrg_p2.exc);
    cause = 5'd0;
    if (take && !irq_req)
      cause = mrg_p2.code;
  end

  assign flush = take | eret_m;

  // Redirect only matters while flushing: the handler on entry, EPC on a
  // plain eret. Idle cycles show the handler address.
  assign redirect = (eret_m & ~take) ? epc : HANDLER;

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_p0 <= '0;
      rec_p1 <= '0;
      rec_p2 <= '0;
      exl    <= 1'b0;
      epc    <= '0;
      bd     <= 1'b0;
      ip     <= '0;
    end else begin
      ip <= hw_int;
      if (take) begin
        // take outranks both eret and stall
        epc    <= epc_of(mrg_p2);
        bd     <= mrg_p2.bd;
        exl    <= 1'b1;
        rec_p0 <= '0;
        rec_p1 <= '0;
        rec_p2 <= '0;
      end else if (eret_m) begin
        exl    <= 1'b0;
        rec_p0 <= '0;
        rec_p1 <= '0;
        rec_p2 <= '0;
      end else begin
        // D/E/M shift; under stall D keeps its merged record and E gets a bubble
        rec_p2 <= mrg_p1;
        rec_p1 <= stall ? '0 : mrg_p0;
        rec_p0 <= stall ? mrg_p0 : rec_f;
      end
    end
  end

endmodule
